// File: rtl/mem_pkg.sv
// Shared types and defaults for the SRAM memory-stage controller.
// Holds the FSM state encoding, default timing and base-address constants,
// and the byte-to-word address helper.
package mem_pkg;

   localparam int unsigned DEFAULT_WAIT_CYCLES = 4;
   localparam logic [31:0] DEFAULT_BASE_ADDR   = 32'd1024;

   // Wide enough for the largest legal WAIT_CYCLES (15).
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } mem_state_e;

   // Byte address relative to the SRAM window, expressed in 32-bit words.
   // Addresses below the base wrap around; the caller truncates the result.
   function automatic logic [31:0] word_index(input logic [31:0] byte_addr,
                                              input logic [31:0] base);
      return (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter that times the SRAM access phase.
// Load has priority over decrement; the count saturates at zero.
module mem_wait_counter
   import mem_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [CNT_W-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: load a fresh wait value or step down toward zero.
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // Count register, cleared immediately by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Memory-stage SRAM controller: turns pipeline load/store requests into
// multi-cycle SRAM accesses and stalls the pipeline (ready low) meanwhile.
// Optional feature: define MEM_LAST_READ_BUF_EN to add a one-entry buffer
// holding the most recently read word, which lets a repeated load of that
// word complete in IDLE without touching the SRAM.
module mem_sram_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = DEFAULT_WAIT_CYCLES,  // legal 1..15
   parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
   parameter int unsigned ADDR_W      = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] SRAM_ADDR,
   output logic [31:0]       SRAM_WDATA,
   output logic              SRAM_WE_N,
   input  logic [31:0]       SRAM_RDATA
);

   localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(WAIT_CYCLES - 1);

   mem_state_e        state_q, state_d;
   logic [ADDR_W-1:0] sram_addr_q, sram_addr_d;
   logic [31:0]       sram_wdata_q, sram_wdata_d;
   logic              write_q, write_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              cnt_load;
   logic              cnt_dec;
   logic              cnt_zero;

   logic [ADDR_W-1:0] word_addr;
   logic              access_end;
   logic              rd_hit;
   logic [31:0]       hit_data;

   assign word_addr  = ADDR_W'(word_index(addr, BASE_ADDR));
   assign access_end = (state_q == ACCESS) && cnt_zero;

   mem_wait_counter u_wait_counter (
      .clk        (clk),
      .rst        (rst),
      .load_i     (cnt_load),
      .load_val_i (LOAD_VAL),
      .dec_i      (cnt_dec),
      .zero_o     (cnt_zero)
   );

`ifdef MEM_LAST_READ_BUF_EN
   logic              buf_valid_q, buf_valid_d;
   logic [ADDR_W-1:0] buf_tag_q, buf_tag_d;
   logic [31:0]       buf_data_q, buf_data_d;

   // A pure read (a simultaneous write wins) of the buffered word is a hit.
   assign rd_hit   = (state_q == IDLE) && MEM_R_EN && !MEM_W_EN &&
                     buf_valid_q && (buf_tag_q == word_addr);
   assign hit_data = buf_data_q;

   // Buffer update at the end of each access: reads refill it, writes to
   // the buffered word keep its copy coherent.
   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      buf_data_d  = buf_data_q;
      if (access_end) begin
         if (!write_q) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = sram_addr_q;
            buf_data_d  = SRAM_RDATA;
         end else if (buf_valid_q && (buf_tag_q == sram_addr_q)) begin
            buf_data_d  = sram_wdata_q;
         end
      end
   end

   // Buffer registers; reset only invalidates the entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
         buf_data_q  <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
         buf_data_q  <= buf_data_d;
      end
   end
`else
   assign rd_hit   = 1'b0;
   assign hit_data = '0;
`endif

   // Next-state and ready logic for the IDLE -> ACCESS -> DONE sequence.
   always_comb begin
      state_d      = state_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      write_d      = write_q;
      rdata_d      = rdata_q;
      ready        = 1'b0;
      cnt_load     = 1'b0;
      cnt_dec      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (rd_hit) begin
               // Served from the buffer: no stall, latch the word for later.
               ready   = 1'b1;
               rdata_d = hit_data;
            end else if (MEM_R_EN || MEM_W_EN) begin
               sram_addr_d  = word_addr;
               sram_wdata_d = wdata;
               write_d      = MEM_W_EN;
               cnt_load     = 1'b1;
               state_d      = ACCESS;
            end else begin
               ready = 1'b1;
            end
         end
         ACCESS: begin
            if (cnt_zero) begin
               state_d = DONE;
               if (!write_q) begin
                  rdata_d = SRAM_RDATA;
               end
            end else begin
               cnt_dec = 1'b1;
            end
         end
         DONE: begin
            // Single completion cycle; requests still asserted are not
            // looked at until the controller is back in IDLE.
            ready   = 1'b1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and SRAM-facing registers, forced to safe values by reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         write_q      <= 1'b0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         write_q      <= write_d;
         rdata_q      <= rdata_d;
      end
   end

   // Write strobe decoded from state so reset drops it without a clock.
   assign SRAM_WE_N  = !((state_q == ACCESS) && write_q);
   assign SRAM_ADDR  = sram_addr_q;
   assign SRAM_WDATA = sram_wdata_q;
   assign rdata      = rd_hit ? hit_data : rdata_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Self-checking bench for mem_sram_ctrl: directed scenarios followed by
// random loads/stores checked against a word-level memory model.
// Buffer expectations follow MEM_LAST_READ_BUF_EN when it is defined.
module tb_mem_sram_ctrl;

   localparam int          W    = 4;
   localparam logic [31:0] BASE = 32'd1024;
   localparam int          AW   = 17;
`ifdef MEM_LAST_READ_BUF_EN
   localparam bit BUF_EN = 1'b1;
`else
   localparam bit BUF_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          MEM_R_EN, MEM_W_EN;
   logic [31:0]   addr, wdata, rdata;
   logic          ready;
   logic [AW-1:0] SRAM_ADDR;
   logic [31:0]   SRAM_WDATA;
   logic          SRAM_WE_N;
   logic [31:0]   SRAM_RDATA;

   int checks = 0;
   int errors = 0;

   // Reference model: word-addressed memory, last load value, read buffer.
   logic [31:0] ref_mem [int unsigned];
   logic [31:0] ref_rdata;
   bit          bm_valid;
   int unsigned bm_tag;
   logic [31:0] bm_data;

   mem_sram_ctrl #(.WAIT_CYCLES(W), .BASE_ADDR(BASE), .ADDR_W(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .MEM_R_EN   (MEM_R_EN),
      .MEM_W_EN   (MEM_W_EN),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .SRAM_ADDR  (SRAM_ADDR),
      .SRAM_WDATA (SRAM_WDATA),
      .SRAM_WE_N  (SRAM_WE_N),
      .SRAM_RDATA (SRAM_RDATA)
   );

   always #5 clk = ~clk;

   // SRAM device: stores on a low write strobe, presents the addressed word.
   initial begin
      logic [31:0] sram [0:(1<<AW)-1];
      for (int i = 0; i < (1 << AW); i++) sram[i] = 32'h0;
      sram[2] = 32'h12345678;
      forever begin
         @(negedge clk);
         if (SRAM_WE_N === 1'b0) sram[SRAM_ADDR] = SRAM_WDATA;
         SRAM_RDATA = sram[SRAM_ADDR];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int unsigned word_of(input logic [31:0] a);
      logic [31:0] d;
      d = a - BASE;
      return (d >> 2) & ((32'd1 << AW) - 1);
   endfunction

   function automatic logic [31:0] ref_get(input int unsigned k);
      return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
   endfunction

   // One pipeline request: present it, measure the stall, check the result.
   task automatic xact(input string tag, input bit r, input bit w,
                       input logic [31:0] a, input logic [31:0] d);
      int          low     = 0;
      int          we_low  = 0;
      bit          seen    = 0;
      int unsigned wa      = word_of(a);
      bit          hit     = BUF_EN && r && !w && bm_valid && (bm_tag == wa);
      int          exp_low = ((r || w) && !hit) ? W + 1 : 0;
      @(posedge clk); #1;
      MEM_R_EN = r; MEM_W_EN = w; addr = a; wdata = d;
      for (int c = 0; c < 4 * W + 20 && !seen; c++) begin
         @(negedge clk);
         if (ready === 1'b1) seen = 1;
         else begin
            low++;
            if (SRAM_WE_N === 1'b0) we_low++;
         end
      end
      if (w) begin
         ref_mem[wa] = d;
         if (bm_valid && bm_tag == wa) bm_data = d;
      end else if (r) begin
         ref_rdata = ref_get(wa);
         bm_valid = 1; bm_tag = wa; bm_data = ref_rdata;
      end
      $display("xact %s r=%0d w=%0d addr=%0h wdata=%0h stall=%0d rdata=%0h",
               tag, r, w, a, d, low, rdata);
      chk({tag, ".done"}, 32'(seen), 32'd1);
      chk({tag, ".stall"}, low, exp_low);
      chk({tag, ".we_cycles"}, we_low, w ? W : 0);
      chk({tag, ".rdata"}, rdata, ref_rdata);
      if ((r || w) && !hit) chk({tag, ".sram_addr"}, 32'(SRAM_ADDR), wa);
      if (w) chk({tag, ".sram_wdata"}, SRAM_WDATA, d);
   endtask

   initial begin
      int n;
      int we_low;
      int rdy_low;
      rst = 1'b0; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; addr = '0; wdata = '0;
      ref_rdata = '0; bm_valid = 0; bm_tag = 0; bm_data = '0;
      ref_mem[2] = 32'h12345678;

      // Reset state
      repeat (2) @(negedge clk);
      chk("reset.ready", 32'(ready), 32'd1);
      chk("reset.rdata", rdata, 32'h0);
      chk("reset.we_n", 32'(SRAM_WE_N), 32'd1);
      chk("reset.sram_addr", 32'(SRAM_ADDR), 32'h0);
      @(posedge clk); #1 rst = 1'b1;

      // Directed write, read, completion-cycle, both-requests, repeat read
      xact("wr", 0, 1, 32'd1028, 32'hDEADBEEF);
      xact("rd", 1, 0, 32'd1032, 32'h0);
      @(negedge clk);
      chk("rd.next_cycle_ready", 32'(ready), 32'(BUF_EN));
      n = 0;
      while (ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
      chk("rd.repeat_done", 32'(ready), 32'd1);
      chk("rd.repeat_rdata", rdata, 32'h12345678);
      xact("both", 1, 1, 32'd1024, 32'hA5A5A5A5);
      xact("rd_again", 1, 0, 32'd1032, 32'h0);

      // Reset in the second ACCESS cycle of a write
      @(posedge clk); #1;
      MEM_R_EN = 0; MEM_W_EN = 1; addr = BASE + 32'd400; wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(posedge clk); #1;
      chk("rst_mid.we_before", 32'(SRAM_WE_N), 32'd0);
      rst = 1'b0; #1;
      chk("rst_mid.we_async", 32'(SRAM_WE_N), 32'd1);
      chk("rst_mid.rdata", rdata, 32'h0);
      MEM_W_EN = 0;
      ref_rdata = '0; bm_valid = 0;
      @(posedge clk); #1 rst = 1'b1;
      we_low = 0; rdy_low = 0;
      repeat (10) begin
         @(negedge clk);
         if (SRAM_WE_N !== 1'b1) we_low++;
         if (ready !== 1'b1) rdy_low++;
      end
      $display("xact rst_mid we_low=%0d ready_low=%0d", we_low, rdy_low);
      chk("rst_mid.no_retry_we", we_low, 0);
      chk("rst_mid.idle_ready", rdy_low, 0);

      // Random loads/stores, including idle cycles and wrapped addresses
      for (int i = 0; i < 40; i++) begin
         bit          r = 1'($urandom_range(0, 1));
         bit          w = 1'($urandom_range(0, 1));
         int unsigned k = $urandom_range(0, 15);
         logic [31:0] a = BASE + 32'(4 * k);
         if ($urandom_range(0, 7) == 0) a = BASE - 32'(4 * (k + 1));
         xact($sformatf("rnd%0d", i), r, w, a, $urandom);
      end

      @(posedge clk); #1;
      MEM_R_EN = 0; MEM_W_EN = 0;
      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
